// File: rtl/ppc_types.sv
// rtl/ppc_types.sv - shared add/sub decode and reservation-station operand types
package ppc_types;

   localparam int RS_TAG_WIDTH = 5;

   typedef logic [RS_TAG_WIDTH-1:0] rs_tag_t;

   typedef struct packed {
      logic is_sub;
      logic add_CA;
      logic set_CA;
      logic set_OV;
      logic set_CR0;
   } add_sub_decode_t;

   typedef struct packed {
      logic        valid;
      rs_tag_t     tag;
      logic [31:0] value;
   } rs_operand_t;

   typedef struct packed {
      logic    valid;
      rs_tag_t tag;
      logic    value;
   } rs_carry_t;

   // A pending operand whose producer tag is on the bus becomes valid with the bus value.
   function automatic rs_operand_t snoop_operand(rs_operand_t op, logic cdb_valid,
                                                 rs_tag_t cdb_tag, logic [31:0] cdb_value);
      rs_operand_t res;
      res = op;
      if (!op.valid && cdb_valid && op.tag == cdb_tag) begin
         res.valid = 1'b1;
         res.value = cdb_value;
      end
      return res;
   endfunction

   function automatic rs_carry_t snoop_carry(rs_carry_t op, logic cdb_valid,
                                             rs_tag_t cdb_tag, logic cdb_ca);
      rs_carry_t res;
      res = op;
      if (!op.valid && cdb_valid && op.tag == cdb_tag) begin
         res.valid = 1'b1;
         res.value = cdb_ca;
      end
      return res;
   endfunction

endpackage

// File: rtl/rs_priority_select.sv
// rtl/rs_priority_select.sv - lowest-index one-hot grant and index from a request vector
module rs_priority_select #(
   parameter int N = 4,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx,
   output logic         any
);

   always_comb begin
      grant = '0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = W'(i);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/add_sub_rs.sv
// rtl/add_sub_rs.sv - add/sub reservation station with CDB wakeup and in-order-by-index issue
module add_sub_rs
   import ppc_types::*;
#(
   parameter int RS_DEPTH    = 4,
   parameter int RS_ID_WIDTH = 5,
   parameter int RS_ID_BASE  = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   dispatch_valid,
   output logic                   dispatch_ready,
   input  logic [31:0]            dispatch_op1,
   input  logic [31:0]            dispatch_op2,
   input  logic                   dispatch_op1_valid,
   input  logic                   dispatch_op2_valid,
   input  logic [RS_ID_WIDTH-1:0] dispatch_op1_tag,
   input  logic [RS_ID_WIDTH-1:0] dispatch_op2_tag,
   input  logic                   dispatch_carry,
   input  logic                   dispatch_carry_valid,
   input  logic [RS_ID_WIDTH-1:0] dispatch_carry_tag,
   input  add_sub_decode_t        dispatch_control,
   input  logic [4:0]             dispatch_result_reg_addr,
   input  logic                   cdb_valid,
   input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
   input  logic [31:0]            cdb_result,
   input  logic                   cdb_ca,
   output logic                   issue_valid,
   input  logic                   issue_ready,
   output logic [RS_ID_WIDTH-1:0] issue_rs_id,
   output logic [4:0]             issue_result_reg_addr,
   output logic [31:0]            issue_op1,
   output logic [31:0]            issue_op2,
   output logic                   issue_carry,
   output add_sub_decode_t        issue_control
);

   localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

   logic [RS_DEPTH-1:0] busy;
   add_sub_decode_t     ctrl_q [RS_DEPTH];
   logic [4:0]          addr_q [RS_DEPTH];
   rs_operand_t         op1_q  [RS_DEPTH];
   rs_operand_t         op2_q  [RS_DEPTH];
   rs_carry_t           ca_q   [RS_DEPTH];

   logic [RS_DEPTH-1:0] ready_vec;
   logic [RS_DEPTH-1:0] free_grant;
   logic [RS_DEPTH-1:0] ready_grant;
   logic [RS_DEPTH-1:0] busy_nxt;
   logic [IDX_W-1:0]    free_idx;
   logic [IDX_W-1:0]    ready_idx;
   logic                free_any;
   logic                ready_any;
   logic                dispatch_fire;
   logic                issue_load;
   rs_tag_t             cdb_tag;

   assign cdb_tag = rs_tag_t'(cdb_rs_id);

   always_comb begin
      ready_vec = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         ready_vec[i] = busy[i] & op1_q[i].valid & op2_q[i].valid & ca_q[i].valid;
      end
   end

   rs_priority_select #(.N(RS_DEPTH)) u_free_sel (
      .req   (~busy),
      .grant (free_grant),
      .idx   (free_idx),
      .any   (free_any)
   );

   rs_priority_select #(.N(RS_DEPTH)) u_ready_sel (
      .req   (ready_vec),
      .grant (ready_grant),
      .idx   (ready_idx),
      .any   (ready_any)
   );

   assign dispatch_ready = free_any;
   assign dispatch_fire  = dispatch_valid & free_any;
   assign issue_load     = (~issue_valid | issue_ready) & ready_any;

   // An entry leaving for the issue register is never the one being written by dispatch.
   assign busy_nxt = (busy & ~(issue_load ? ready_grant : '0))
                   | (dispatch_fire ? free_grant : '0);

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         busy                  <= '0;
         issue_valid           <= 1'b0;
         issue_rs_id           <= '0;
         issue_result_reg_addr <= '0;
         issue_op1             <= '0;
         issue_op2             <= '0;
         issue_carry           <= 1'b0;
         issue_control         <= '0;
      end else begin
         busy <= busy_nxt;
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (busy[i]) begin
               op1_q[i] <= snoop_operand(op1_q[i], cdb_valid, cdb_tag, cdb_result);
               op2_q[i] <= snoop_operand(op2_q[i], cdb_valid, cdb_tag, cdb_result);
               ca_q[i]  <= snoop_carry(ca_q[i], cdb_valid, cdb_tag, cdb_ca);
            end
         end
         if (dispatch_fire) begin
            ctrl_q[free_idx] <= dispatch_control;
            addr_q[free_idx] <= dispatch_result_reg_addr;
            op1_q[free_idx]  <= snoop_operand(rs_operand_t'{dispatch_op1_valid,
                                   rs_tag_t'(dispatch_op1_tag), dispatch_op1},
                                   cdb_valid, cdb_tag, cdb_result);
            op2_q[free_idx]  <= snoop_operand(rs_operand_t'{dispatch_op2_valid,
                                   rs_tag_t'(dispatch_op2_tag), dispatch_op2},
                                   cdb_valid, cdb_tag, cdb_result);
            ca_q[free_idx]   <= snoop_carry(rs_carry_t'{dispatch_carry_valid,
                                   rs_tag_t'(dispatch_carry_tag), dispatch_carry},
                                   cdb_valid, cdb_tag, cdb_ca);
         end
         if (issue_load) begin
            issue_valid           <= 1'b1;
            issue_rs_id           <= RS_ID_WIDTH'(RS_ID_BASE + int'(ready_idx));
            issue_result_reg_addr <= addr_q[ready_idx];
            issue_op1             <= op1_q[ready_idx].value;
            issue_op2             <= op2_q[ready_idx].value;
            issue_carry           <= ca_q[ready_idx].value;
            issue_control         <= ctrl_q[ready_idx];
         end else if (issue_ready) begin
            issue_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_add_sub_rs.sv
// tb/tb_add_sub_rs.sv - randomized and directed checks of add_sub_rs against a slot-level model
module tb_add_sub_rs;
   import ppc_types::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, flush, dispatch_valid, dispatch_ready;
   logic [31:0] dispatch_op1, dispatch_op2;
   logic dispatch_op1_valid, dispatch_op2_valid;
   logic [4:0] dispatch_op1_tag, dispatch_op2_tag, dispatch_carry_tag;
   logic dispatch_carry, dispatch_carry_valid;
   add_sub_decode_t dispatch_control;
   logic [4:0] dispatch_result_reg_addr;
   logic cdb_valid, cdb_ca;
   logic [4:0] cdb_rs_id;
   logic [31:0] cdb_result;
   logic issue_valid, issue_ready, issue_carry;
   logic [4:0] issue_rs_id, issue_result_reg_addr;
   logic [31:0] issue_op1, issue_op2;
   add_sub_decode_t issue_control;

   add_sub_rs #(.RS_DEPTH(DEPTH), .RS_ID_WIDTH(5), .RS_ID_BASE(0)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_op1(dispatch_op1), .dispatch_op2(dispatch_op2),
      .dispatch_op1_valid(dispatch_op1_valid), .dispatch_op2_valid(dispatch_op2_valid),
      .dispatch_op1_tag(dispatch_op1_tag), .dispatch_op2_tag(dispatch_op2_tag),
      .dispatch_carry(dispatch_carry), .dispatch_carry_valid(dispatch_carry_valid),
      .dispatch_carry_tag(dispatch_carry_tag), .dispatch_control(dispatch_control),
      .dispatch_result_reg_addr(dispatch_result_reg_addr),
      .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result), .cdb_ca(cdb_ca),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
      .issue_result_reg_addr(issue_result_reg_addr), .issue_op1(issue_op1),
      .issue_op2(issue_op2), .issue_carry(issue_carry), .issue_control(issue_control)
   );

   // Model: slot k of an entry is op1 (0), op2 (1) or carry (2).
   bit          m_busy [DEPTH];
   bit          m_have [DEPTH][3];
   logic [4:0]  m_tag  [DEPTH][3];
   logic [31:0] m_val  [DEPTH][3];
   logic [4:0]  m_ctrl [DEPTH];
   logic [4:0]  m_addr [DEPTH];
   bit          m_iv;
   logic [4:0]  m_irs, m_iaddr, m_ictrl;
   logic [31:0] m_iop1, m_iop2;
   bit          m_ica;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int model_count();
      int n = 0;
      foreach (m_busy[i]) if (m_busy[i]) n++;
      return n;
   endfunction

   task automatic model_step();
      int oldest_ready, first_free, occupied;
      bit [2:0]    d_have;
      logic [4:0]  d_tag [3];
      logic [31:0] d_val [3];
      if (!rst || flush) begin
         foreach (m_busy[i]) m_busy[i] = 0;
         m_iv = 0; m_irs = 0; m_iaddr = 0; m_ictrl = 0; m_iop1 = 0; m_iop2 = 0; m_ica = 0;
         return;
      end
      oldest_ready = -1;
      first_free = -1;
      occupied = model_count();
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (m_busy[i] && m_have[i][0] && m_have[i][1] && m_have[i][2]) oldest_ready = i;
         if (!m_busy[i]) first_free = i;
      end
      if (oldest_ready >= 0 && (!m_iv || issue_ready)) begin
         m_iv    = 1;
         m_irs   = 5'(oldest_ready);
         m_iop1  = m_val[oldest_ready][0];
         m_iop2  = m_val[oldest_ready][1];
         m_ica   = m_val[oldest_ready][2][0];
         m_iaddr = m_addr[oldest_ready];
         m_ictrl = m_ctrl[oldest_ready];
         m_busy[oldest_ready] = 0;
      end else if (issue_ready) begin
         m_iv = 0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         for (int k = 0; k < 3; k++) begin
            if (m_busy[i] && !m_have[i][k] && cdb_valid && m_tag[i][k] == cdb_rs_id) begin
               m_have[i][k] = 1;
               m_val[i][k]  = (k == 2) ? {31'd0, cdb_ca} : cdb_result;
            end
         end
      end
      if (dispatch_valid && occupied < DEPTH) begin
         d_have = {dispatch_carry_valid, dispatch_op2_valid, dispatch_op1_valid};
         d_tag[0] = dispatch_op1_tag; d_tag[1] = dispatch_op2_tag; d_tag[2] = dispatch_carry_tag;
         d_val[0] = dispatch_op1; d_val[1] = dispatch_op2; d_val[2] = {31'd0, dispatch_carry};
         m_busy[first_free] = 1;
         m_ctrl[first_free] = dispatch_control;
         m_addr[first_free] = dispatch_result_reg_addr;
         for (int k = 0; k < 3; k++) begin
            m_have[first_free][k] = d_have[k];
            m_tag[first_free][k]  = d_tag[k];
            m_val[first_free][k]  = d_val[k];
            if (!d_have[k] && cdb_valid && d_tag[k] == cdb_rs_id) begin
               m_have[first_free][k] = 1;
               m_val[first_free][k]  = (k == 2) ? {31'd0, cdb_ca} : cdb_result;
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("issue_valid", issue_valid, m_iv);
      check("dispatch_ready", dispatch_ready, model_count() < DEPTH);
      if (m_iv) begin
         check("issue_rs_id", issue_rs_id, m_irs);
         check("issue_op1", issue_op1, m_iop1);
         check("issue_op2", issue_op2, m_iop2);
         check("issue_carry", issue_carry, m_ica);
         check("issue_addr", issue_result_reg_addr, m_iaddr);
         check("issue_control", issue_control, m_ictrl);
      end
   endtask

   task automatic idle();
      dispatch_valid = 0; cdb_valid = 0; flush = 0;
   endtask

   task automatic disp(input bit v1, input logic [4:0] t1, input logic [31:0] x1,
                       input bit v2, input logic [4:0] t2, input logic [31:0] x2,
                       input bit vc, input logic [4:0] tc, input bit c,
                       input logic [4:0] ctrl, input logic [4:0] addr);
      dispatch_valid = 1;
      dispatch_op1_valid = v1; dispatch_op1_tag = t1; dispatch_op1 = x1;
      dispatch_op2_valid = v2; dispatch_op2_tag = t2; dispatch_op2 = x2;
      dispatch_carry_valid = vc; dispatch_carry_tag = tc; dispatch_carry = c;
      dispatch_control = add_sub_decode_t'(ctrl);
      dispatch_result_reg_addr = addr;
   endtask

   task automatic cdb(input logic [4:0] tag, input logic [31:0] val, input bit ca);
      cdb_valid = 1; cdb_rs_id = tag; cdb_result = val; cdb_ca = ca;
   endtask

   initial begin
      rst = 0; issue_ready = 0;
      idle();
      disp(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      dispatch_valid = 0;
      cdb(0, 0, 0);
      cdb_valid = 0;

      // 1: reset, then a fully ready add issues after two edges
      tick(); tick();
      check("rst_issue_valid", issue_valid, 0);
      check("rst_issue_op1", issue_op1, 0);
      check("rst_issue_rs_id", issue_rs_id, 0);
      check("rst_dispatch_ready", dispatch_ready, 1);
      rst = 1;
      disp(1, 0, 5, 1, 0, 7, 1, 0, 0, 5'b00000, 5'd3);
      issue_ready = 1;
      tick(); idle();
      check("t1_not_yet", issue_valid, 0);
      tick();
      check("t1_valid", issue_valid, 1);
      check("t1_op1", issue_op1, 5);
      check("t1_op2", issue_op2, 7);
      check("t1_rs_id", issue_rs_id, 0);
      tick();

      // 2: op1 waits on tag 9
      disp(0, 9, 0, 1, 0, 2, 1, 0, 0, 5'b00000, 5'd4);
      tick(); idle(); tick(); tick();
      cdb(9, 32'h0000_00FF, 0);
      tick(); idle();
      check("t2_not_yet", issue_valid, 0);
      tick();
      check("t2_valid", issue_valid, 1);
      check("t2_op1", issue_op1, 32'hFF);
      tick();

      // 3: CDB in the dispatch cycle is captured
      disp(0, 9, 0, 1, 0, 1, 1, 0, 0, 5'b10000, 5'd5);
      cdb(9, 32'h1234, 0);
      tick(); idle();
      tick();
      check("t3_valid", issue_valid, 1);
      check("t3_op1", issue_op1, 32'h1234);
      tick();

      // 4: fill, stall, then drain in entry order
      issue_ready = 0;
      for (int k = 0; k < 4; k++) begin
         disp(0, 20, 0, 1, 0, 100 + k, 1, 0, 0, 5'b00000, 5'(k));
         tick();
      end
      idle();
      check("t4_full", dispatch_ready, 0);
      cdb(20, 32'hAA, 0);
      tick(); idle();
      tick();
      check("t4_first_rs_id", issue_rs_id, 0);
      check("t4_ready_after_first", dispatch_ready, 1);
      tick(); tick();
      check("t4_stall_rs_id", issue_rs_id, 0);
      check("t4_stall_op2", issue_op2, 100);
      issue_ready = 1;
      for (int k = 1; k < 4; k++) begin
         tick();
         check("t4_order", issue_rs_id, 5'(k));
         check("t4_order_op2", issue_op2, 100 + k);
      end
      tick();
      check("t4_drained", issue_valid, 0);

      // 5: pending carry woken by CA
      disp(1, 0, 1, 1, 0, 1, 0, 3, 0, 5'b01000, 5'd6);
      tick(); idle();
      cdb(3, 0, 1);
      tick(); idle();
      tick();
      check("t5_valid", issue_valid, 1);
      check("t5_carry", issue_carry, 1);
      tick();

      // 6: flush drops the issue register and waiting entries
      issue_ready = 0;
      disp(1, 0, 11, 1, 0, 12, 1, 0, 0, 5'b00000, 5'd7);
      tick();
      for (int k = 0; k < 3; k++) begin
         disp(0, 25, 0, 1, 0, 1, 1, 0, 0, 5'b00000, 5'd8);
         tick();
      end
      idle();
      check("t6_before_valid", issue_valid, 1);
      flush = 1;
      disp(0, 25, 0, 1, 0, 1, 1, 0, 0, 5'b00000, 5'd9);
      cdb(25, 32'h55, 0);
      tick(); idle();
      check("t6_flushed_valid", issue_valid, 0);
      check("t6_flushed_ready", dispatch_ready, 1);
      cdb(25, 32'h55, 0);
      tick(); idle(); tick();
      check("t6_no_stale_issue", issue_valid, 0);

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(199) != 0);
         flush = ($urandom_range(79) == 0);
         issue_ready = ($urandom_range(3) != 0);
         disp($urandom_range(1), 5'($urandom_range(15, 8)), $urandom,
              $urandom_range(1), 5'($urandom_range(15, 8)), $urandom,
              $urandom_range(1), 5'($urandom_range(15, 8)), $urandom_range(1),
              5'($urandom), 5'($urandom));
         dispatch_valid = ($urandom_range(2) != 0);
         cdb_valid = ($urandom_range(9) < 4);
         cdb_rs_id = 5'($urandom_range(15, 6));
         cdb_result = $urandom;
         cdb_ca = $urandom_range(1);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
